// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants plus helpers for deriving axis totals
// and for confirming at elaboration that a counter width can hold them.
package vga_timing_pkg;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_CW        = 10;

    function automatic int unsigned axis_total(
        input int unsigned display,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return display + front + sync + back;
    endfunction

    // True when a CW-bit counter can represent every count of both axes.
    function automatic bit cw_fits(
        input int unsigned cw,
        input int unsigned h_total,
        input int unsigned v_total
    );
        longint unsigned span;
        span = longint'(1) << cw;
        return (span >= longint'(h_total)) && (span >= longint'(v_total));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Mod-TOTAL axis counter with display/sync window decode; advances one step per inc_i,
// wrap_o is combinational from inc_i, all window outputs decode registered count only.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW      = 10,
    parameter int unsigned DISPLAY = 640,
    parameter int unsigned FRONT   = 16,
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BACK    = 48,
    parameter bit          POL     = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o,
    output logic          display_o,
    output logic          sync_o
);

    localparam int unsigned   TOTAL    = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    // One extra bit so window edges equal to 2^CW still compare correctly.
    localparam logic [CW:0]   DISP_END = (CW+1)'(DISPLAY);
    localparam logic [CW:0]   SYNC_BEG = (CW+1)'(DISPLAY + FRONT);
    localparam logic [CW:0]   SYNC_END = (CW+1)'(DISPLAY + FRONT + SYNC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   cnt_x;
    logic          at_last;
    logic          in_sync;

    assign at_last = (cnt_q == LAST);
    assign wrap_o  = inc_i & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_x     = {1'b0, cnt_q};
    assign display_o = (cnt_x < DISP_END);
    assign in_sync   = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);
    assign sync_o    = in_sync ? POL : ~POL;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters, sync/blank decode and strobes.
// Outputs follow registered state one clk after each tick; en=0 freezes everything.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pixel_tick,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic [CW-1:0] x_loc,
    output logic [CW-1:0] y_loc,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned      H_TOTAL  = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned      V_TOTAL  = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (!cw_fits(CW, H_TOTAL, V_TOTAL)) begin : g_cw_too_small
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1) begin : g_clk_div_zero
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             div_last;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic [CW-1:0]    h_cnt;
    logic [CW-1:0]    v_cnt;
    logic             h_disp;
    logic             v_disp;

    // With CLK_DIV=1 the divider stays at 0 and div_last is permanently true.
    assign div_last = (div_q == DIV_LAST);
    assign tick     = en & ~reset & div_last;

    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = div_last ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    vga_axis_counter #(
        .CW      (CW),
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (tick),
        .cnt_o     (h_cnt),
        .wrap_o    (h_wrap),
        .display_o (h_disp),
        .sync_o    (h_sync)
    );

    vga_axis_counter #(
        .CW      (CW),
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (VSYNC_POL)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (h_wrap),
        .cnt_o     (v_cnt),
        .wrap_o    (v_wrap_unused),
        .display_o (v_disp),
        .sync_o    (v_sync)
    );

    assign pixel_tick  = tick;
    assign video_on    = h_disp & v_disp;
    assign line_start  = tick & (h_cnt == '0);
    assign frame_start = line_start & (v_cnt == '0);
    assign x_loc       = h_cnt;
    assign y_loc       = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance (A) for line-level timing and a tiny 16x11
// instance (B, inverted polarity, CLK_DIV=1) for whole-frame, hold and reset cases.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, en_a, tick_a, hs_a, vs_a, von_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       reset_b, en_b, tick_b, hs_b, vs_b, von_b, ls_b, fs_b;
    logic [4:0] x_b, y_b;

    obs_t exp_a[$];
    obs_t exp_b[$];
    int   checks   = 0;
    int   failures = 0;

    vga_timing_gen #(
        .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .CLK_DIV(4), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(10)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .en(en_a), .pixel_tick(tick_a),
        .h_sync(hs_a), .v_sync(vs_a), .video_on(von_a),
        .x_loc(x_a), .y_loc(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(5)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .pixel_tick(tick_b),
        .h_sync(hs_b), .v_sync(vs_b), .video_on(von_b),
        .x_loc(x_b), .y_loc(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    // Expected view of the k-th pixel tick after reset (800x525, h sync 656..751, v sync 490..491).
    function automatic obs_t exp_a_at(input int k);
        obs_t o;
        int   x, y;
        x     = k % 800;
        y     = (k / 800) % 525;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.hs  = !(x >= 656 && x < 752);
        o.vs  = !(y >= 490 && y < 492);
        o.von = (x < 640) && (y < 480);
        o.ls  = (x == 0);
        o.fs  = (x == 0) && (y == 0);
        return o;
    endfunction

    // 16x11 geometry: visible 8x6, h sync 10..12, v sync 7..8, both active-high.
    function automatic obs_t exp_b_at(input int k);
        obs_t o;
        int   x, y;
        x     = k % 16;
        y     = (k / 16) % 11;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.hs  = (x >= 10 && x < 13);
        o.vs  = (y >= 7 && y < 9);
        o.von = (x < 8) && (y < 6);
        o.ls  = (x == 0);
        o.fs  = (x == 0) && (y == 0);
        return o;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic score(input string name, input obs_t got, input bit have, input obs_t want);
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL %s_unexpected_tick: got tick at x=%0d y=%0d, expected no tick",
                     name, got.x, got.y);
        end else if (got !== want) begin
            failures++;
            $display("FAIL %s_tick: got x=%0d y=%0d hs=%0b vs=%0b von=%0b ls=%0b fs=%0b, expected x=%0d y=%0d hs=%0b vs=%0b von=%0b ls=%0b fs=%0b",
                     name, got.x, got.y, got.hs, got.vs, got.von, got.ls, got.fs,
                     want.x, want.y, want.hs, want.vs, want.von, want.ls, want.fs);
        end
    endtask

    task automatic monitor_loop();
        obs_t got, want;
        bit   have;
        forever begin
            @(negedge clk);
            if (!reset_a) begin
                if (tick_a) begin
                    got  = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, von: von_a, ls: ls_a, fs: fs_a};
                    have = (exp_a.size() != 0);
                    want = have ? exp_a.pop_front() : '0;
                    score("a", got, have, want);
                end else begin
                    check("a_idle_strobes", int'({ls_a, fs_a}), 0);
                end
            end
            if (!reset_b) begin
                if (tick_b) begin
                    got  = '{x: {5'd0, x_b}, y: {5'd0, y_b}, hs: hs_b, vs: vs_b,
                             von: von_b, ls: ls_b, fs: fs_b};
                    have = (exp_b.size() != 0);
                    want = have ? exp_b.pop_front() : '0;
                    score("b", got, have, want);
                end else begin
                    check("b_idle_strobes", int'({ls_b, fs_b}), 0);
                end
            end
        end
    endtask

    task automatic wait_drain(input bit use_b, input int bound, input string name);
        int n = 0;
        while ((use_b ? exp_b.size() : exp_a.size()) != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        check(name, use_b ? exp_b.size() : exp_a.size(), 0);
    endtask

    task automatic first_tick_a(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 20);
        check(name, n, 4);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_x"}, int'(x_a), 0);
        check({tag, "_y"}, int'(y_a), 0);
        check({tag, "_video_on"}, int'(von_a), 1);
        check({tag, "_h_sync"}, int'(hs_a), 1);
        check({tag, "_v_sync"}, int'(vs_a), 1);
        check({tag, "_strobes"}, int'({tick_a, ls_a, fs_a}), 0);
    endtask

    task automatic check_reset_b(input string tag);
        check({tag, "_x"}, int'(x_b), 0);
        check({tag, "_y"}, int'(y_b), 0);
        check({tag, "_video_on"}, int'(von_b), 1);
        check({tag, "_h_sync"}, int'(hs_b), 0);
        check({tag, "_v_sync"}, int'(vs_b), 0);
        check({tag, "_strobes"}, int'({tick_b, ls_b, fs_b}), 0);
    endtask

    initial begin
        reset_a = 1'b1;
        en_a    = 1'b1;
        reset_b = 1'b1;
        en_b    = 1'b0;
        fork
            monitor_loop();
        join_none

        // A: reset state, latency, one full line plus 300 pixels of the next.
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("a_reset");
        for (int k = 0; k < 1100; k++) exp_a.push_back(exp_a_at(k));
        reset_a = 1'b0;
        first_tick_a("a_first_tick_clks");
        wait_drain(1'b0, 5000, "a_line_drain");
        #1;
        en_a = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("a_hold_x", int'(x_a), 300);
            check("a_hold_y", int'(y_a), 1);
            check("a_hold_tick", int'(tick_a), 0);
        end

        // A: asynchronous reset mid-line, then the same start-up timing again.
        #2;
        reset_a = 1'b1;
        #1;
        check_reset_a("a_midreset");
        en_a = 1'b1;
        for (int k = 0; k < 4; k++) exp_a.push_back(exp_a_at(k));
        @(posedge clk);
        #1;
        check_reset_a("a_reset_held");
        reset_a = 1'b0;
        first_tick_a("a_restart_tick_clks");
        wait_drain(1'b0, 50, "a_restart_drain");
        #1;
        en_a = 1'b0;

        // B: reset with en high still gives no tick; then two frames minus one pixel.
        @(posedge clk);
        #1;
        en_b = 1'b1;
        #1;
        check_reset_b("b_reset");
        reset_b = 1'b0;
        for (int k = 0; k <= 350; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            exp_b.push_back(exp_b_at(k));
            if (k < 3) begin
                #1;
                check("b_tick_const_high", int'(tick_b), 1);
            end
        end

        // B: en dropped at the last pixel of the frame; nothing may move.
        @(posedge clk);
        #1;
        en_b = 1'b0;
        check("b_drained_at_wrap", exp_b.size(), 0);
        repeat (50) begin
            @(posedge clk);
            #1;
            check("b_hold_x", int'(x_b), 15);
            check("b_hold_y", int'(y_b), 10);
            check("b_hold_strobes", int'({tick_b, ls_b, fs_b}), 0);
        end
        for (int k = 351; k <= 443; k++) begin
            if (k > 351) begin
                @(posedge clk);
                #1;
            end
            en_b = 1'b1;
            exp_b.push_back(exp_b_at(k));
        end

        // B: reset mid-frame at (12,5), then restart from (0,0).
        @(posedge clk);
        #1;
        check("b_pre_reset_x", int'(x_b), 12);
        check("b_pre_reset_y", int'(y_b), 5);
        check("b_pre_reset_drained", exp_b.size(), 0);
        reset_b = 1'b1;
        #1;
        check_reset_b("b_midreset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_b("b_reset_held");
        reset_b = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            exp_b.push_back(exp_b_at(k));
        end
        @(posedge clk);
        #1;
        en_b = 1'b0;
        wait_drain(1'b1, 20, "b_restart_drain");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Self-contained, parametrised VGA timing generator for the video path. It owns the pixel-clock divider and the horizontal/vertical counters, and drives sync, blanking and pixel coordinates. It also produces line and frame strobes for the game-logic and pixel-generation blocks. It replaces any external counter plus pure sync-decode arrangement, and it supports arbitrary resolutions, programmable sync polarity and a clock-enable-based pixel rate.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width
- V_BACK, 33, vertical back porch
- CLK_DIV, 4, system clocks per pixel (≥1; 100 MHz → 25 MHz)
- HSYNC_POL, 0, active level of h_sync (0 = active-low)
- VSYNC_POL, 0, active level of v_sync
- CW, 10, counter/coordinate width; must satisfy 2^CW ≥ max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes divider and counters
- pixel_tick  out  1  one-clk strobe, one per pixel period
- h_sync  out  1  horizontal sync, polarity per HSYNC_POL
- v_sync  out  1  vertical sync, polarity per VSYNC_POL
- video_on  out  1  high while the current pixel is in the visible area
- x_loc  out  CW  current horizontal count, 0..H_TOTAL-1
- y_loc  out  CW  current vertical count, 0..V_TOTAL-1
- line_start  out  1  strobe on the tick consuming x=0
- frame_start  out  1  strobe on the tick consuming x=0, y=0

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default); V_TOTAL is defined the same way (525 by default).
- Divider div counts 0..CLK_DIV-1 while en=1. pixel_tick = en && div==CLK_DIV-1. With CLK_DIV=1, pixel_tick = en.
- On a pixel_tick, h advances; at h==H_TOTAL-1 it wraps to 0 and v advances. At v==V_TOTAL-1 with an h wrap, v wraps to 0. All arithmetic is unsigned CW-bit, and there is no overflow beyond H_TOTAL-1 or V_TOTAL-1.
- x_loc = h and y_loc = v. Both report raw counts during blanking as well.
- video_on = (h < H_DISPLAY) && (v < V_DISPLAY). The comparisons are strict.
- The h sync window is h ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC).
  - Inside the window, h_sync = HSYNC_POL.
  - Outside the window, h_sync = ~HSYNC_POL.
  - v_sync follows the same rule using the V parameters.
- line_start = pixel_tick && h==0. frame_start = line_start && v==0.
- With en=0, all state holds, so outputs are static and both strobes plus pixel_tick are 0. Raising en resumes from the held state.
- Reset values:
  - div=0, h=0, v=0.
  - x_loc=0, y_loc=0, video_on=1.
  - h_sync=~HSYNC_POL, v_sync=~VSYNC_POL.
  - pixel_tick=0, line_start=0, frame_start=0.

## Timing
- All outputs are decoded from registered state only. They change one clk after the pixel_tick that advances the counters, and there are no combinational paths from inputs to outputs except through en on the strobes.
- Latency from reset deassertion with en=1 to the first pixel_tick is CLK_DIV clks. frame_start coincides with that first tick.
- Reset asserted mid-frame forces the reset values asynchronously. The next frame restarts at (0,0) with no partial strobes.
- If en is deasserted on the same clk as a wrap tick, the wrap does not occur. The counters hold at H_TOTAL-1 or V_TOTAL-1.
- Per frame at default parameters: 420000 pixel_ticks and 1680000 clks.

## Structure
- Shared package vga_timing_pkg contains the default 640x480@60 porch/sync constants and the H_TOTAL/V_TOTAL derivation functions. It also contains a compile-time check that CW is sufficient.
- One sub-module, vga_axis_counter, is instantiated twice (h and v). It is a mod-N counter with inc input, wrap output, window decode (display, sync) and polarity.
- The divider and strobe decode are implemented in the top level.

## Test plan
- Reset with en=1 and CLK_DIV=4 → pixel_tick first rises 4 clks after release. frame_start and line_start coincide with it, and x_loc/y_loc = 0/0.
- Run one full line → line_start every 800 ticks. h_sync is low exactly for x=656..751, and video_on drops at x=640.
- Run one full frame → v_sync is low exactly for y=490..491. video_on=0 for y≥480, and frame_start repeats after 420000 ticks.
- HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1 → pixel_tick is constantly high, and both syncs are inverted from the default-polarity windows.
- en low for 50 clks at x=799, y=524 → state holds with no strobes. On re-enable, the next tick wraps to (0,0) with frame_start=1.
- Assert reset at x=300, y=200 → outputs take their reset values immediately, and after release timing matches the post-reset scenario.
